// File: rtl/rv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv_fetch_pkg
//  Shared types and constants for the RV32I fetch sequencer.
//  - fetch_state_t : BOOT / REQ / WAIT sequencer states
//  - INSTR_BYTES   : size of one instruction word, used as the PC stride
//  - DEFAULT_*     : default reset vector and NOP word (addi x0,x0,0)
//  - align_pc      : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Instructions are word aligned, so the low two address bits are forced to 0.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//  Instruction-memory fetch bus: req/ready request handshake plus an rvalid
//  response strobe carrying the fetched word.
//  - req    : fetch request valid            (master -> slave)
//  - addr   : fetch address, word aligned    (master -> slave)
//  - ready  : memory accepts the request     (slave  -> master)
//  - rvalid : response word valid            (slave  -> master)
//  - rdata  : response word                  (slave  -> master)
//  The fetch sequencer is the master, the instruction memory is the slave.
// ---------------------------------------------------------------------------
interface fetch_sequencer_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//  Owns the architectural fetch PC for the RV32I core. Issues one imem request
//  at a time, presents the returned word and its PC to decode, holds it while
//  decode stalls, and follows execute-stage redirects. A response that belongs
//  to a fetch killed by a redirect is dropped when it finally arrives.
//
//  Ports
//   clk            in   1   clock, all state updates on posedge
//   rst            in   1   synchronous active-high reset
//   stall_i        in   1   decode cannot accept; hold the output word
//   redirect_i     in   1   taken branch/jump from execute
//   redirect_pc_i  in   32  redirect target, low two bits ignored
//   imem           master   fetch bus (req/addr/ready/rvalid/rdata)
//   instr_o        out  32  fetched instruction
//   instr_pc_o     out  32  PC of instr_o
//   instr_valid_o  out  1   instr_o / instr_pc_o valid
//   flush_o        out  1   pulse the cycle after a redirect is sampled
// ---------------------------------------------------------------------------
module fetch_sequencer
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        instr_o,
    output logic [31:0]        instr_pc_o,
    output logic               instr_valid_o,
    output logic               flush_o
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inflight_pc;
    logic [31:0] inflight_pc_next;
    logic        drop;
    logic        drop_next;
    logic [31:0] instr_next;
    logic [31:0] instr_pc_next;
    logic        instr_valid_next;
    logic [31:0] redirect_target;
    logic        issue;

    assign redirect_target = align_pc(redirect_pc_i);

    // A request goes out only when the output register is empty or is being
    // consumed this cycle, so a returning word always has somewhere to land.
    assign issue     = (state == REQ) && !redirect_i && !(instr_valid_o && stall_i);
    assign imem.req  = issue;
    assign imem.addr = pc;

    // Register stage: every piece of sequencer state, with reset taking
    // priority over everything including a redirect in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= align_pc(RESET_VECTOR);
            inflight_pc   <= align_pc(RESET_VECTOR);
            drop          <= 1'b0;
            instr_o       <= NOP_INSTR;
            instr_pc_o    <= align_pc(RESET_VECTOR);
            instr_valid_o <= 1'b0;
            flush_o       <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            inflight_pc   <= inflight_pc_next;
            drop          <= drop_next;
            instr_o       <= instr_next;
            instr_pc_o    <= instr_pc_next;
            instr_valid_o <= instr_valid_next;
            flush_o       <= redirect_i;
        end
    end

    // Next-state logic. Everything holds by default; the output register
    // drains when decode takes the word, then the state-specific updates
    // apply, and finally a redirect invalidates whatever decode would see.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        inflight_pc_next = inflight_pc;
        drop_next        = drop;
        instr_next       = instr_o;
        instr_pc_next    = instr_pc_o;
        instr_valid_next = instr_valid_o;

        if (instr_valid_o && !stall_i) begin
            instr_valid_next = 1'b0;
        end

        unique case (state)
            BOOT: begin
                state_next = REQ;
                if (redirect_i) begin
                    pc_next = redirect_target;
                end
            end

            REQ: begin
                if (redirect_i) begin
                    pc_next = redirect_target;
                end else if (issue && imem.ready) begin
                    state_next       = WAIT;
                    inflight_pc_next = pc;
                end
            end

            WAIT: begin
                if (imem.rvalid) begin
                    state_next = REQ;
                    drop_next  = 1'b0;
                    if (drop || redirect_i) begin
                        if (redirect_i) begin
                            pc_next = redirect_target;
                        end
                    end else begin
                        instr_next       = imem.rdata;
                        instr_pc_next    = inflight_pc;
                        instr_valid_next = 1'b1;
                        pc_next          = inflight_pc + 32'(INSTR_BYTES);
                    end
                end else if (redirect_i) begin
                    // The outstanding response is now stale; remember to
                    // discard it, because the bus can only carry one.
                    pc_next   = redirect_target;
                    drop_next = 1'b1;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase

        if (redirect_i) begin
            instr_valid_next = 1'b0;
        end
    end

endmodule
